// File: rtl/k_and_s_mem_responder.sv
// Data-memory responder for the K-and-S control unit: one load/store in flight, preload port while idle.
// Latency: request accepted at edge E, ack pulses in the cycle after edge E+WAIT_CYCLES.
// Backpressure: busy while a transaction is in flight; req/preload in WAIT are ignored, preload wins over req in IDLE.
module k_and_s_mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   mem_q [2**ADDR_W];

    logic                latch_en;
    logic                commit;
    logic                load_wr;
    logic [ADDR_W-1:0]   cmt_addr;
    logic                cmt_we;
    logic [DATA_W-1:0]   cmt_wdata;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_en  = 1'b0;
        commit    = 1'b0;
        load_wr   = 1'b0;
        cmt_addr  = addr_q;
        cmt_we    = we_q;
        cmt_wdata = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    load_wr = 1'b1;
                end else if (req) begin
                    latch_en = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        // Zero-wait build commits straight from the live inputs on the accept edge
                        state_d   = S_RESPOND;
                        commit    = 1'b1;
                        cmt_addr  = addr;
                        cmt_we    = we;
                        cmt_wdata = wdata;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESPOND;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Preload and commit are mutually exclusive: a commit from IDLE requires load_en low
    always_comb begin
        mem_we    = load_wr | (commit & cmt_we);
        mem_waddr = load_wr ? load_addr : cmt_addr;
        mem_wdata = load_wr ? load_data : cmt_wdata;
        rdata_d   = (commit && !cmt_we) ? mem_q[cmt_addr] : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (latch_en) begin
                addr_q  <= addr;
                we_q    <= we;
                wdata_q <= wdata;
            end
        end
    end

    // Memory contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rdata = rdata_q;
    assign ack   = (state_q == S_RESPOND);
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_k_and_s_mem_responder.sv
// Directed bench for k_and_s_mem_responder: 1-, 0- and 15-wait-state builds side by side.
module tb_k_and_s_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, req0, req15;
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [15:0] load_data;
    logic [15:0] rdata1, rdata0, rdata15;
    logic        ack1, ack0, ack15;
    logic        busy1, busy0, busy15;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    k_and_s_mem_responder #(.DATA_W(16), .ADDR_W(5), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ack(ack1), .busy(busy1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    k_and_s_mem_responder #(.DATA_W(16), .ADDR_W(5), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ack(ack0), .busy(busy0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    k_and_s_mem_responder #(.DATA_W(16), .ADDR_W(5), .WAIT_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst), .req(req15), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata15), .ack(ack15), .busy(busy15),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    // One read on the 1-wait build: accept edge, wait edge, then ack cycle
    task automatic read1(input string tag, input logic [4:0] a, input logic [15:0] exp);
        req1 = 1'b1; we = 1'b0; addr = a;
        tick();
        chk({tag, "_wait_ack"}, 32'(ack1), 32'd0);
        tick();
        chk({tag, "_ack"}, 32'(ack1), 32'd1);
        chk({tag, "_rdata"}, 32'(rdata1), 32'(exp));
        req1 = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; req1 = 0; req0 = 0; req15 = 0; we = 0; addr = '0; wdata = '0;
        load_en = 0; load_addr = '0; load_data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_ack",   32'(ack1),   32'd0);
        chk("rst_busy",  32'(busy1),  32'd0);
        chk("rst_rdata", 32'(rdata1), 32'd0);
        chk("rst_rdata15", 32'(rdata15), 32'd0);

        // Preloaded read, busy for exactly two cycles
        preload(5'd3, 16'hBEEF);
        req1 = 1'b1; we = 1'b0; addr = 5'd3;
        tick();
        chk("rd3_busy_wait", 32'(busy1), 32'd1);
        chk("rd3_ack_wait",  32'(ack1),  32'd0);
        tick();
        chk("rd3_ack",   32'(ack1),   32'd1);
        chk("rd3_busy",  32'(busy1),  32'd1);
        chk("rd3_rdata", 32'(rdata1), 32'hBEEF);
        req1 = 1'b0;
        tick();
        chk("rd3_ack_end",  32'(ack1),  32'd0);
        chk("rd3_busy_end", 32'(busy1), 32'd0);

        // Write top address, then read it back with req held through the turnaround
        req1 = 1'b1; we = 1'b1; addr = 5'd31; wdata = 16'h1234;
        tick();
        tick();
        chk("wr31_ack",   32'(ack1),   32'd1);
        chk("wr31_rdata", 32'(rdata1), 32'hBEEF);
        we = 1'b0; wdata = 16'h0000;
        tick();
        chk("rb31_idle_ack",  32'(ack1),  32'd0);
        chk("rb31_idle_busy", 32'(busy1), 32'd0);
        tick();
        chk("rb31_wait_busy", 32'(busy1), 32'd1);
        tick();
        chk("rb31_ack",   32'(ack1),   32'd1);
        chk("rb31_rdata", 32'(rdata1), 32'h1234);
        req1 = 1'b0;
        tick();

        // Preload and request in the same IDLE cycle: preload first, request next cycle
        load_en = 1'b1; load_addr = 5'd5; load_data = 16'h00AA;
        req1 = 1'b1; we = 1'b0; addr = 5'd5;
        tick();
        load_en = 1'b0;
        chk("ld5_idle_busy", 32'(busy1), 32'd0);
        tick();
        chk("ld5_wait_busy", 32'(busy1), 32'd1);
        tick();
        chk("ld5_ack",   32'(ack1),   32'd1);
        chk("ld5_rdata", 32'(rdata1), 32'h00AA);
        req1 = 1'b0;
        tick();

        // Reset while a write waits: nothing committed, outputs clear at once
        preload(5'd7, 16'h0001);
        req1 = 1'b1; we = 1'b1; addr = 5'd7; wdata = 16'hFFFF;
        tick();
        chk("rst7_busy_pre", 32'(busy1), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst7_ack",   32'(ack1),   32'd0);
        chk("rst7_busy",  32'(busy1),  32'd0);
        chk("rst7_rdata", 32'(rdata1), 32'd0);
        #1 rst = 1'b0; req1 = 1'b0;
        tick();
        read1("rst7_readback", 5'd7, 16'h0001);

        // Input changes and preload during WAIT are ignored
        preload(5'd9,  16'h1111);
        preload(5'd10, 16'h2222);
        req1 = 1'b1; we = 1'b1; addr = 5'd9; wdata = 16'h5555;
        tick();
        we = 1'b0; addr = 5'd10; wdata = 16'h9999;
        load_en = 1'b1; load_addr = 5'd10; load_data = 16'h7777;
        tick();
        load_en = 1'b0; req1 = 1'b0;
        chk("chg_ack",   32'(ack1),   32'd1);
        chk("chg_rdata", 32'(rdata1), 32'h0001);
        tick();
        read1("chg_rd9",  5'd9,  16'h5555);
        read1("chg_rd10", 5'd10, 16'h2222);

        // Zero-wait build: ack the cycle right after the accept edge
        preload(5'd0, 16'hC0DE);
        req0 = 1'b1; we = 1'b0; addr = 5'd0;
        tick();
        chk("w0_ack",   32'(ack0),   32'd1);
        chk("w0_rdata", 32'(rdata0), 32'hC0DE);
        req0 = 1'b0;
        tick();
        chk("w0_ack_end", 32'(ack0), 32'd0);

        // Fifteen-wait build: ack only after edge E+15, one cycle wide
        req15 = 1'b1; we = 1'b0; addr = 5'd0;
        tick();
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("w15_noack_%0d", k), 32'(ack15), 32'd0);
            tick();
        end
        chk("w15_ack",   32'(ack15),   32'd1);
        chk("w15_rdata", 32'(rdata15), 32'hC0DE);
        req15 = 1'b0;
        tick();
        chk("w15_ack_end",  32'(ack15),  32'd0);
        chk("w15_busy_end", 32'(busy15), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
